load_unit: RTL

- Read-side data-memory port for the ARM core. Accepts one load (LDR/LDRB) from the pipeline, issues a word-aligned read on the data-memory bus and waits for the response.
- Aligns or extracts the result, then presents it to writeback through a valid/ready handshake.
- Allows one outstanding load at a time. A timeout counter converts a hung bus into an error response.

---
 rtl/load_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/load_unit.sv
// Single-outstanding load port: issues an aligned word read, then aligns or extracts the
// result and returns it to writeback. A REQ+WAIT cycle counter turns a hung bus into an error.
module load_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int RD_WIDTH   = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  input  logic                  ld_byte_i,
  input  logic [RD_WIDTH-1:0]   ld_rd_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_err_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [31:0]           wb_data_o,
  output logic [RD_WIDTH-1:0]   wb_rd_o,
  output logic                  wb_err_o,
  output logic                  busy_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [1:0]            off_q, off_d;
  logic                  byte_q, byte_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [31:0]           wb_data_q, wb_data_d;
  logic [RD_WIDTH-1:0]   wb_rd_q, wb_rd_d;
  logic                  wb_err_q, wb_err_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [63:0] rot64;
  logic [31:0] result;
  logic        timeout;

  // Rotating right by the byte offset also lands the addressed byte in [7:0].
  assign rot64   = {mem_rdata_i, mem_rdata_i} >> {off_q, 3'b000};
  assign result  = byte_q ? {24'b0, rot64[7:0]} : rot64[31:0];
  assign timeout = (cnt_q == CW'(TIMEOUT - 1));

  assign ld_ready_o = (state_q == IDLE) && reset_ni;
  assign busy_o     = (state_q != IDLE);
  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;
  assign wb_valid_o = wb_valid_q;
  assign wb_data_o  = wb_data_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_err_o   = wb_err_q;

  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    byte_d     = byte_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_err_d   = wb_err_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: if (ld_valid_i) begin
        off_d      = ld_addr_i[1:0];
        byte_d     = ld_byte_i;
        wb_rd_d    = ld_rd_i;
        mem_req_d  = 1'b1;
        mem_addr_d = {ld_addr_i[ADDR_WIDTH-1:2], 2'b00};
        cnt_d      = '0;
        state_d    = REQ;
      end
      REQ: begin
        cnt_d = cnt_q + CW'(1);
        // The last allowed cycle ends in error even if a grant shows up in it.
        if (timeout) begin
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_err_d   = 1'b1;
          wb_data_d  = '0;
          state_d    = RESP;
        end else if (mem_gnt_i) begin
          mem_req_d = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_rvalid_i) begin
          wb_valid_d = 1'b1;
          wb_err_d   = mem_err_i;
          wb_data_d  = mem_err_i ? 32'b0 : result;
          state_d    = RESP;
        end else if (timeout) begin
          wb_valid_d = 1'b1;
          wb_err_d   = 1'b1;
          wb_data_d  = '0;
          state_d    = RESP;
        end
      end
      RESP: if (wb_ready_i) begin
        wb_valid_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      off_q      <= '0;
      byte_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_err_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      byte_q     <= byte_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_err_q   <= wb_err_d;
      cnt_q      <= cnt_d;
    end
  end
endmodule
